// File: rtl/router_out_arb.sv
// Output-port stage: round-robin arbiter over NUM_IN input FIFOs feeding an OUT_DEPTH-entry buffer.
// Define ROUTER_OUT_ARB_STATS_EN to add the word_count / stall_count statistics ports.
module router_out_arb #(
    parameter int NUM_IN    = 17,
    parameter int DATA_W    = 16,
    parameter int OUT_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_IN-1:0]             req_valid,
    input  logic [NUM_IN*DATA_W-1:0]      req_data,
    output logic [NUM_IN-1:0]             req_ready,
    output logic [DATA_W-1:0]             data_out,
    output logic                          valid_out,
    input  logic                          ready_out,
    output logic [$clog2(OUT_DEPTH):0]    occupancy
`ifdef ROUTER_OUT_ARB_STATS_EN
    ,
    output logic [31:0]                   word_count,
    output logic [31:0]                   stall_count
`endif
);

    localparam int AW = $clog2(OUT_DEPTH);
    localparam int PW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    logic [PW-1:0]     ptr_q, ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]       occ_q, occ_d;
    logic [DATA_W-1:0] mem_q [OUT_DEPTH];

    logic              full;
    logic              push;
    logic              pop;
    logic              hi_found;
    logic              lo_found;
    logic [PW-1:0]     hi_idx;
    logic [PW-1:0]     lo_idx;
    logic [PW-1:0]     grant_idx;
    logic [DATA_W-1:0] push_data;

    assign full      = (occ_q == (AW+1)'(OUT_DEPTH));
    assign valid_out = (occ_q != '0);
    assign data_out  = valid_out ? mem_q[rd_ptr_q] : '0;
    assign occupancy = occ_q;

    // Lowest requester at or above ptr wins; otherwise wrap to the lowest requester overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_found = 1'b1;
                lo_idx   = PW'(i);
                if (PW'(i) >= ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = PW'(i);
                end
            end
        end
        grant_idx = hi_found ? hi_idx : lo_idx;
        req_ready = '0;
        if ((hi_found || lo_found) && !full && !reset) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign push      = |(req_valid & req_ready);
    assign pop       = valid_out & ready_out;
    assign push_data = req_data[grant_idx*DATA_W +: DATA_W];

    always_comb begin
        ptr_d    = ptr_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            ptr_d    = (grant_idx == PW'(NUM_IN - 1)) ? '0 : grant_idx + PW'(1);
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + (AW+1)'(1);
            2'b01:   occ_d = occ_q - (AW+1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            ptr_q    <= ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage needs no reset: stale entries are hidden by valid_out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

`ifdef ROUTER_OUT_ARB_STATS_EN
    logic [31:0] word_count_q, word_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        word_count_d  = word_count_q;
        stall_count_d = stall_count_q;
        if (pop && (word_count_q != 32'hFFFF_FFFF)) begin
            word_count_d = word_count_q + 32'd1;
        end
        if (valid_out && !ready_out && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_count_q  <= '0;
            stall_count_q <= '0;
        end else begin
            word_count_q  <= word_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign word_count  = word_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_router_out_arb.sv
// Self-checking bench for router_out_arb: queue-based reference model plus directed scenarios.
// Stats checks are compiled in when ROUTER_OUT_ARB_STATS_EN is defined.
module tb_router_out_arb;

    localparam int NUM_IN    = 17;
    localparam int DATA_W    = 16;
    localparam int OUT_DEPTH = 4;

    logic                     clk;
    logic                     reset;
    logic [NUM_IN-1:0]        req_valid;
    logic [NUM_IN*DATA_W-1:0] req_data;
    logic [NUM_IN-1:0]        req_ready;
    logic [DATA_W-1:0]        data_out;
    logic                     valid_out;
    logic                     ready_out;
    logic [2:0]               occupancy;
`ifdef ROUTER_OUT_ARB_STATS_EN
    logic [31:0]              word_count;
    logic [31:0]              stall_count;
`endif

    router_out_arb #(
        .NUM_IN   (NUM_IN),
        .DATA_W   (DATA_W),
        .OUT_DEPTH(OUT_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .ready_out  (ready_out),
        .occupancy  (occupancy)
`ifdef ROUTER_OUT_ARB_STATS_EN
        ,
        .word_count (word_count),
        .stall_count(stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vectors     = 0;
    int n_miscompares = 0;

    // Reference model state: buffered words in arrival order and the round-robin start index.
    logic [DATA_W-1:0] mq [$];
    int                mptr        = 0;
    bit                model_valid = 1'b0;
    longint            m_words     = 0;
    longint            m_stalls    = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [NUM_IN-1:0] rv, input logic rdy);
        @(posedge clk);
        #1;
        reset     = rst;
        req_valid = rv;
        ready_out = rdy;
        @(negedge clk);
    endtask

    task automatic setDataIndex();
        for (int i = 0; i < NUM_IN; i++) begin
            req_data[i*DATA_W +: DATA_W] = DATA_W'(i);
        end
    endtask

    function automatic logic [NUM_IN-1:0] bitOf(input int n);
        logic [NUM_IN-1:0] v;
        v = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    // Compare every cycle against the model, then advance the model with the inputs the next edge will see.
    always @(negedge clk) begin : compare_proc
        logic [NUM_IN-1:0] exp_ready;
        logic [DATA_W-1:0] exp_data;
        int g;
        int idx;
        exp_ready = '0;
        g = -1;
        if (!reset && (mq.size() < OUT_DEPTH)) begin
            for (int k = 0; k < NUM_IN; k++) begin
                idx = (mptr + k) % NUM_IN;
                if ((g < 0) && req_valid[idx]) g = idx;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        exp_data = (mq.size() != 0) ? mq[0] : '0;
        if (model_valid) begin
            checkOutput("model_req_ready", 32'(req_ready), 32'(exp_ready));
            checkOutput("model_valid_out", 32'(valid_out), 32'(mq.size() != 0));
            checkOutput("model_data_out", 32'(data_out), 32'(exp_data));
            checkOutput("model_occupancy", 32'(occupancy), 32'(mq.size()));
`ifdef ROUTER_OUT_ARB_STATS_EN
            checkOutput("model_word_count", word_count, 32'(m_words));
            checkOutput("model_stall_count", stall_count, 32'(m_stalls));
`endif
        end
        if (reset) begin
            mq.delete();
            mptr        = 0;
            m_words     = 0;
            m_stalls    = 0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (mq.size() != 0) begin
                if (ready_out) begin
                    void'(mq.pop_front());
                    if (m_words < 64'h0000_0000_FFFF_FFFF) m_words++;
                end else begin
                    if (m_stalls < 64'h0000_0000_FFFF_FFFF) m_stalls++;
                end
            end
            if (g >= 0) begin
                mq.push_back(req_data[g*DATA_W +: DATA_W]);
                mptr = (g + 1) % NUM_IN;
            end
        end
    end

    initial begin
        reset     = 1'b1;
        req_valid = '1;
        ready_out = 1'b0;
        req_data  = '0;
        setDataIndex();

        // Reset held two cycles with every input requesting.
        applyStimulus(1'b1, '1, 1'b0);
        applyStimulus(1'b1, '1, 1'b0);
        checkOutput("reset_req_ready", 32'(req_ready), 32'h0);
        checkOutput("reset_valid_out", 32'(valid_out), 32'h0);
        checkOutput("reset_data_out", 32'(data_out), 32'h0);
        checkOutput("reset_occupancy", 32'(occupancy), 32'h0);

        // Single request from input 5; the following grant shows ptr moved to 6.
        req_data[5*DATA_W +: DATA_W] = 16'hA5A5;
        applyStimulus(1'b0, 17'h00020, 1'b1);
        checkOutput("single_req_ready", 32'(req_ready), 32'h00020);
        applyStimulus(1'b0, 17'h00090, 1'b1);
        checkOutput("single_data_out", 32'(data_out), 32'hA5A5);
        checkOutput("single_valid_out", 32'(valid_out), 32'h1);
        checkOutput("single_ptr_next", 32'(req_ready), 32'h00080);
        applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        setDataIndex();

        // Round robin with everyone requesting and the output always ready.
        applyStimulus(1'b1, '0, 1'b0);
        for (int c = 0; c < 18; c++) begin
            applyStimulus(1'b0, '1, 1'b1);
            checkOutput("rr_grant", 32'(req_ready), 32'(bitOf(c % NUM_IN)));
            if (c > 0) begin
                checkOutput("rr_data_out", 32'(data_out), 32'(c - 1));
                checkOutput("rr_valid_out", 32'(valid_out), 32'h1);
            end
        end

        // Backpressure: inputs 2 and 9 fill the buffer, then drain in order.
        applyStimulus(1'b1, '0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0, 17'h00204, 1'b0);
            checkOutput("bp_grant", 32'(req_ready), (c % 2 == 0) ? 32'h00004 : 32'h00200);
        end
        applyStimulus(1'b0, 17'h00204, 1'b0);
        checkOutput("bp_full_occupancy", 32'(occupancy), 32'h4);
        checkOutput("bp_full_no_grant", 32'(req_ready), 32'h0);
        applyStimulus(1'b0, 17'h00204, 1'b1);
        checkOutput("bp_pop0_data", 32'(data_out), 32'h2);
        checkOutput("bp_pop_cycle_no_grant", 32'(req_ready), 32'h0);
        applyStimulus(1'b0, 17'h00204, 1'b1);
        checkOutput("bp_pop1_data", 32'(data_out), 32'h9);
        checkOutput("bp_regrant", 32'(req_ready), 32'h00004);
        applyStimulus(1'b0, 17'h00204, 1'b1);
        checkOutput("bp_pop2_data", 32'(data_out), 32'h2);
        applyStimulus(1'b0, 17'h00204, 1'b1);
        checkOutput("bp_pop3_data", 32'(data_out), 32'h9);
        for (int c = 0; c < 5; c++) applyStimulus(1'b0, '0, 1'b1);

        // Reset in the middle of a stream discards words and restarts the pointer at 0.
        applyStimulus(1'b1, '0, 1'b0);
        for (int c = 0; c < 3; c++) applyStimulus(1'b0, 17'h00408, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("mid_occupancy3", 32'(occupancy), 32'h3);
        applyStimulus(1'b1, 17'h00408, 1'b0);
        checkOutput("mid_reset_no_grant", 32'(req_ready), 32'h0);
        applyStimulus(1'b0, 17'h01001, 1'b0);
        checkOutput("mid_after_occupancy", 32'(occupancy), 32'h0);
        checkOutput("mid_after_valid_out", 32'(valid_out), 32'h0);
        checkOutput("mid_after_grant0", 32'(req_ready), 32'h00001);

`ifdef ROUTER_OUT_ARB_STATS_EN
        // Ten pops and seven stalled cycles.
        applyStimulus(1'b1, '0, 1'b0);
        for (int c = 0; c < 8; c++) applyStimulus(1'b0, 17'h00002, 1'b0);
        for (int c = 0; c < 7; c++) applyStimulus(1'b0, 17'h00002, 1'b1);
        for (int c = 0; c < 5; c++) applyStimulus(1'b0, '0, 1'b1);
        checkOutput("stats_word_count", word_count, 32'd10);
        checkOutput("stats_stall_count", stall_count, 32'd7);
`endif

        // Randomised traffic with varying request density, backpressure and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            logic [NUM_IN-1:0] rv;
            logic              rdy;
            logic              rst;
            int                phase;
            phase = (c / 250) % 4;
            case (phase)
                0:       rv = NUM_IN'($urandom);
                1:       rv = NUM_IN'($urandom & $urandom & $urandom);
                2:       rv = NUM_IN'($urandom | $urandom);
                default: rv = ($urandom_range(0, 3) == 0) ? '0 : bitOf($urandom_range(0, NUM_IN - 1));
            endcase
            case (phase)
                0:       rdy = ($urandom_range(0, 1) == 1);
                1:       rdy = ($urandom_range(0, 9) < 8);
                2:       rdy = ($urandom_range(0, 9) < 2);
                default: rdy = ($urandom_range(0, 2) != 0);
            endcase
            rst = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < NUM_IN; i++) begin
                req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
            end
            applyStimulus(rst, rv, rdy);
        end

        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/router_out_arb.md
# router_out_arb

Output-port stage of the multiport router. It sits directly downstream of the per-input FIFOs. It arbitrates round-robin among up to NUM_IN input FIFOs that hold a word for this output port, and moves one word per cycle into a small output buffer. It drives the port's `data_out`/`valid_out` pair with valid/ready backpressure. One instance exists per router output port.

## Interface
- `NUM_IN`, 17: number of requesting input FIFOs.
- `DATA_W`, 16: word width.
- `OUT_DEPTH`, 4: output buffer entries; power of two, ≥2.
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high reset.
- `req_valid` input NUM_IN: input i holds a word destined for this port.
- `req_data` input NUM_IN*DATA_W: word of input i at bits [i*DATA_W +: DATA_W].
- `req_ready` output NUM_IN: one-hot grant; a word transfers from input i when `req_valid[i] & req_ready[i]`.
- `data_out` output DATA_W: head word of the output buffer.
- `valid_out` output 1: `data_out` is valid.
- `ready_out` input 1: downstream accepts; the word pops when `valid_out & ready_out`.
- `occupancy` output log2(OUT_DEPTH)+1: number of buffered words.

Clock and reset: one clock; reset is synchronous and active-high (ports `clk`, `reset`).

## Operation
- **Grant.** `req_ready` is combinational from `req_valid`, the RR pointer `ptr` and `full`.
  - When `full`, `req_ready` is all zero.
  - Otherwise it has exactly one bit set: the first set `req_valid` bit scanning from index `ptr` upward, wrapping `NUM_IN-1`→0.
  - With no `req_valid` bits set, `req_ready` is 0.
- **Pointer.** On a transfer from input g, `ptr` becomes `(g+1) mod NUM_IN` at the next edge. With no transfer, `ptr` holds.
- **Buffer.** Circular FIFO with write and read pointers of log2(OUT_DEPTH) bits each, wrapping naturally.
  - `full` = (occupancy == OUT_DEPTH).
  - `valid_out` = (occupancy != 0).
  - `data_out` = mem[rd_ptr], registered memory read, combinational head select.
- **Simultaneous push and pop** (non-full, non-empty): occupancy unchanged and both pointers advance.
- **Push when empty:** the word appears on `data_out`, with `valid_out`=1, in the cycle after the transfer.
- **Pop when occupancy==1 with a simultaneous push:** `valid_out` stays 1 and `data_out` shows the new word next cycle.
- **Full with a pop in the same cycle:** no grant that cycle. The freed slot is grantable on the following cycle.
- **Reset values:** `ptr`=0, rd/wr pointers=0, occupancy=0, `valid_out`=0, `data_out`=0, `req_ready`=0. Buffer memory contents are don't-care but are masked by `valid_out`.
- **Reset mid-operation:** buffered words are discarded. A request asserted during reset is not granted.

## Timing
- Grant-to-output latency is 1 cycle: a word transferred at edge N is visible at `data_out` after edge N.
- Throughput is 1 word/cycle when `ready_out` is held high.
- `data_out` and `valid_out` are stable while `valid_out & !ready_out`.
- `req_ready` never depends on `ready_out` combinationally. Backpressure reaches the inputs only through `full`.
- `req_ready` is a function of `req_valid` in the same cycle. Upstream FIFOs must not make `req_valid` depend on `req_ready`.

## Configuration
- Macro `ROUTER_OUT_ARB_STATS_EN`.
  - **Defined:** adds output ports `word_count` (32 bits) and `stall_count` (32 bits), both cleared by `reset`.
    - `word_count` increments once per pop.
    - `stall_count` increments each cycle with `valid_out & !ready_out`.
    - Both saturate at 32'hFFFF_FFFF.
  - **Undefined:** the ports and counters are absent, and all other behaviour is identical.

## Test plan
- **Reset:** hold `reset` 2 cycles with `req_valid`=all ones → `req_ready`=0, `valid_out`=0, `data_out`=0, `occupancy`=0.
- **Single request:** `req_valid[5]`=1 with data 16'hA5A5, `ready_out`=1 → `req_ready`=17'h00020; one cycle later `data_out`=16'hA5A5, `valid_out`=1; `ptr`=6.
- **Round robin:** all 17 `req_valid` high, each input carrying its own index as data, `ready_out`=1 → grants in order 0,1,…,16,0 and `data_out` sequence 0,1,…,16 with no gaps.
- **Backpressure:** `ready_out`=0, inputs 2 and 9 continuously valid → 4 transfers (2,9,2,9), then `occupancy`=4 and `req_ready`=0. Raise `ready_out` → pops 2,9,2,9 in order, and the next grant occurs one cycle after the first pop.
- **Reset mid-stream:** `occupancy`=3 and `reset` pulsed 1 cycle → next cycle `occupancy`=0, `valid_out`=0, and a subsequent request from input 0 is granted first.
- **Stats** (with `ROUTER_OUT_ARB_STATS_EN`): 10 pops and 7 stalled cycles → `word_count`=10 and `stall_count`=7.
